// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Latency: none (declarations only).
// Backpressure: n/a.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  // Width codes with no meaning, or an unsigned variant on a store.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of the lane-selected memory read data.
// Latency: purely combinational.
// Backpressure: none.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] ext_data
);

  // Extend according to the load width; words pass straight through.
  always_comb begin
    ext_data = rdata;
    case (funct3)
      F3_B:    ext_data = {{24{rdata[7]}}, rdata[7:0]};
      F3_H:    ext_data = {{16{rdata[15]}}, rdata[15:0]};
      F3_BU:   ext_data = {24'b0, rdata[7:0]};
      F3_HU:   ext_data = {16'b0, rdata[15:0]};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-organised data memory.
// Latency: load response 3 cycles after accept, store 2, fault/misaligned 1.
// Backpressure: req_ready only in IDLE; responses are a one-cycle pulse, no stall.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 8001
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misaligned,
  output logic        rsp_fault,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  MemSize,
  output logic [31:0] A_Ram,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  lsu_state_e  state_q, state_d;
  logic        ready_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        mis_q;
  logic        flt_q;
  logic [31:0] rdata_q;
  logic [31:0] ext_data;

  logic accept;
  logic req_illegal;
  logic req_mis;
  logic req_oor;
  logic req_flt;
  logic bus_active;

  // Accept-time classification; illegal code masks misalignment, which masks range.
  always_comb begin
    accept      = (state_q == ST_IDLE) && ready_q && req_valid;
    req_illegal = f3_illegal(req_funct3, req_we);
    req_mis     = !req_illegal &&
                  (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
    req_oor     = {2'b00, req_addr[31:2]} >= MEM_WORDS;
    req_flt     = req_illegal || (!req_mis && req_oor);
  end

  // State register; ready_q keeps req_ready low until the first edge out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
    end
  end

  // Next-state: rejected requests skip the memory entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = (req_mis || req_flt) ? ST_RESP : ST_ACCESS;
      ST_ACCESS:  state_d = we_q ? ST_RESP : ST_WAIT_RD;
      ST_WAIT_RD: state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Request capture at accept, load data capture at the end of WAIT_RD.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      mis_q   <= req_mis;
      flt_q   <= req_flt;
      rdata_q <= 32'h0;
    end else if (state_q == ST_WAIT_RD) begin
      rdata_q <= ext_data;
    end
  end

  lsu_load_ext u_load_ext (
    .funct3   (f3_q),
    .rdata    (ReadData),
    .ext_data (ext_data)
  );

  // Outputs decoded from registered state; the memory bus is held from ACCESS through WAIT_RD.
  always_comb begin
    bus_active     = (state_q == ST_ACCESS) || (state_q == ST_WAIT_RD);
    req_ready      = (state_q == ST_IDLE) && ready_q;
    rsp_valid      = (state_q == ST_RESP);
    rsp_rdata      = rsp_valid ? rdata_q : 32'h0;
    rsp_misaligned = rsp_valid && mis_q;
    rsp_fault      = rsp_valid && flt_q;
    MemRead        = (state_q == ST_ACCESS) && !we_q;
    MemWrite       = (state_q == ST_ACCESS) && we_q;
    MemSize        = 3'b000;
    A_Ram          = 32'h0;
    WriteData      = 32'h0;
    if (bus_active) begin
      case (f3_q[1:0])
        2'b00: begin
          MemSize   = SZ_BYTE;
          A_Ram     = addr_q;
          WriteData = {24'b0, wdata_q[7:0]};
        end
        2'b01: begin
          // Memory picks the half-word by bit 0, so move addr[1] down there.
          MemSize   = SZ_HALF;
          A_Ram     = {addr_q[31:2], 1'b0, addr_q[1]};
          WriteData = {16'b0, wdata_q[15:0]};
        end
        default: begin
          MemSize   = SZ_WORD;
          A_Ram     = addr_q;
          WriteData = wdata_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-level reference memory.
// Latency: n/a.
// Backpressure: n/a.
module tb_load_store_unit;

  localparam int unsigned MEM_WORDS = 8001;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] ReadData = 32'h0;
  logic        req_ready, rsp_valid, rsp_misaligned, rsp_fault, MemRead, MemWrite;
  logic [31:0] rsp_rdata, A_Ram, WriteData;
  logic [2:0]  MemSize;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_misaligned (rsp_misaligned),
    .rsp_fault      (rsp_fault),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .MemSize        (MemSize),
    .A_Ram          (A_Ram),
    .WriteData      (WriteData),
    .ReadData       (ReadData)
  );

  // Attached data memory: word array, lane-selects reads, byte/half writes by lane.
  logic [31:0] dev_mem [int unsigned];
  logic        rd_hold = 1'b0;

  always @(negedge clk) begin : mem_dev
    logic [31:0] w;
    int unsigned idx;
    int          sh;
    idx = {2'b00, A_Ram[31:2]};
    w   = dev_mem.exists(idx) ? dev_mem[idx] : 32'h0;
    if (MemRead) begin
      sh = 8 * int'(A_Ram[1:0]);
      case (MemSize)
        3'b000:  ReadData = (w >> sh) & 32'h0000_00FF;
        3'b001:  ReadData = A_Ram[0] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
        default: ReadData = w;
      endcase
      rd_hold = 1'b1;
    end else if (rd_hold) begin
      rd_hold = 1'b0;
    end else begin
      ReadData = $urandom;
    end
    if (MemWrite) begin
      case (MemSize)
        3'b000:  w[8*int'(A_Ram[1:0]) +: 8] = WriteData[7:0];
        3'b001:  w[16*int'(A_Ram[0]) +: 16] = WriteData[15:0];
        default: w = WriteData;
      endcase
      dev_mem[idx] = w;
    end
  end

  // Reference model: byte-addressed memory, little-endian, rules from the width code.
  logic [7:0] ref_mem [int unsigned];

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
    int          accesses;
  } exp_t;

  typedef struct {
    int          rsp_cyc;
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
    int          n_rd;
    int          n_wr;
    int          n_both;
    int          rd_cyc;
    int          wr_cyc;
    logic [31:0] a1;
    logic [31:0] w1;
    logic [2:0]  s1;
    logic [31:0] a2;
    logic [2:0]  s2;
    logic        rdy_after;
    logic [31:0] idle_bus;
  } obs_t;

  function automatic logic [7:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    int unsigned nbytes;
    int unsigned a;
    logic [31:0] v;
    logic        illegal;
    e.cyc = 0; e.rdata = 32'h0; e.mis = 1'b0; e.flt = 1'b0; e.accesses = 0;
    a       = addr;
    nbytes  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
    if (illegal)                e.flt = 1'b1;
    else if (a % nbytes != 0)   e.mis = 1'b1;
    else if (a / 4 >= MEM_WORDS) e.flt = 1'b1;
    if (e.mis || e.flt) begin
      e.cyc = 1;
    end else if (we) begin
      e.cyc = 2;
      e.accesses = 1;
      for (int i = 0; i < int'(nbytes); i++) ref_mem[a + i] = wd[8*i +: 8];
    end else begin
      e.cyc = 3;
      e.accesses = 1;
      v = 32'h0;
      for (int i = 0; i < int'(nbytes); i++) v[8*i +: 8] = ref_rd(a + i);
      if (f3 < 3'd4 && nbytes == 1) v = {{24{v[7]}}, v[7:0]};
      if (f3 < 3'd4 && nbytes == 2) v = {{16{v[15]}}, v[15:0]};
      e.rdata = v;
    end
    return e;
  endfunction

  // Issue one request and record what the bus and response did, cycle by cycle.
  task automatic drive_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output obs_t o, output exp_t e);
    o.rsp_cyc = 0; o.rdata = 32'h0; o.mis = 1'b0; o.flt = 1'b0;
    o.n_rd = 0; o.n_wr = 0; o.n_both = 0; o.rd_cyc = 0; o.wr_cyc = 0;
    o.a1 = 32'h0; o.w1 = 32'h0; o.s1 = 3'b0; o.a2 = 32'h0; o.s2 = 3'b0;
    o.rdy_after = 1'b0; o.idle_bus = 32'hFFFF_FFFF;
    e = model(we, f3, addr, wd);
    @(negedge clk);
    for (int i = 0; i < 10 && req_ready !== 1'b1; i++) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (MemRead === 1'b1)  begin o.n_rd++; o.rd_cyc = k; end
      if (MemWrite === 1'b1) begin o.n_wr++; o.wr_cyc = k; end
      if (MemRead === 1'b1 && MemWrite === 1'b1) o.n_both++;
      if (k == 1) begin o.a1 = A_Ram; o.w1 = WriteData; o.s1 = MemSize; end
      if (k == 2) begin o.a2 = A_Ram; o.s2 = MemSize; end
      if (rsp_valid === 1'b1) begin
        o.rsp_cyc = k; o.rdata = rsp_rdata; o.mis = rsp_misaligned; o.flt = rsp_fault;
        break;
      end
    end
    @(negedge clk);
    o.rdy_after = req_ready;
    o.idle_bus  = A_Ram | WriteData | {29'b0, MemSize};
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    vectors++;
    if ({rsp_valid, MemRead, MemWrite, rsp_fault, rsp_misaligned} !== 5'b0 || (A_Ram | WriteData | rsp_rdata) !== 32'h0 || MemSize !== 3'b0) begin
      miscompares++; $display("FAIL reset_outputs: rsp_valid=%b MemRead=%b MemWrite=%b A_Ram=%h want all zero", rsp_valid, MemRead, MemWrite, A_Ram);
    end
    resetn = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_loads();
    obs_t o; exp_t e;
    drive_txn(1'b0, 3'b000, 32'h401, 32'h0, o, e);
    vectors++;
    if (o.rd_cyc !== 1 || o.n_rd !== 1) begin miscompares++; $display("FAIL lb_memread: cycle %0d count %0d want cycle 1 count 1", o.rd_cyc, o.n_rd); end
    vectors++;
    if (o.a1 !== 32'h401 || o.s1 !== 3'b000) begin miscompares++; $display("FAIL lb_bus: A_Ram=%h MemSize=%b want 401/000", o.a1, o.s1); end
    vectors++;
    if (o.rsp_cyc !== 3 || o.rdata !== 32'hFFFF_FFF2) begin miscompares++; $display("FAIL lb_data: cycle %0d data %h want 3 FFFFFFF2", o.rsp_cyc, o.rdata); end
    drive_txn(1'b0, 3'b100, 32'h403, 32'h0, o, e);
    vectors++;
    if (o.rdata !== 32'h0000_0080) begin miscompares++; $display("FAIL lbu_data: got %h want 00000080", o.rdata); end
    drive_txn(1'b0, 3'b001, 32'h402, 32'h0, o, e);
    vectors++;
    if (o.a1 !== 32'h401 || o.s1 !== 3'b001) begin miscompares++; $display("FAIL lh_bus: A_Ram=%h MemSize=%b want 401/001", o.a1, o.s1); end
    vectors++;
    if (o.a2 !== o.a1 || o.s2 !== o.s1) begin miscompares++; $display("FAIL lh_bus_stable: wait A_Ram=%h size=%b want %h/%b", o.a2, o.s2, o.a1, o.s1); end
    vectors++;
    if (o.rdata !== 32'hFFFF_8081) begin miscompares++; $display("FAIL lh_data: got %h want FFFF8081", o.rdata); end
    vectors++;
    if (o.rdy_after !== 1'b1 || o.idle_bus !== 32'h0) begin miscompares++; $display("FAIL lh_idle: ready=%b bus=%h want 1/0", o.rdy_after, o.idle_bus); end
    drive_txn(1'b0, 3'b101, 32'h400, 32'h0, o, e);
    vectors++;
    if (o.rdata !== 32'h0000_F2F3) begin miscompares++; $display("FAIL lhu_data: got %h want 0000F2F3", o.rdata); end
  endtask

  task automatic test_stores();
    obs_t o; exp_t e;
    drive_txn(1'b1, 3'b010, 32'h404, 32'hDEAD_BEEF, o, e);
    vectors++;
    if (o.n_wr !== 1 || o.wr_cyc !== 1 || o.n_rd !== 0) begin miscompares++; $display("FAIL sw_strobe: wr cnt %0d cyc %0d rd cnt %0d want 1/1/0", o.n_wr, o.wr_cyc, o.n_rd); end
    vectors++;
    if (o.w1 !== 32'hDEAD_BEEF || o.rsp_cyc !== 2 || o.rdata !== 32'h0) begin miscompares++; $display("FAIL sw_resp: wdata %h cyc %0d rdata %h want DEADBEEF/2/0", o.w1, o.rsp_cyc, o.rdata); end
    drive_txn(1'b0, 3'b010, 32'h404, 32'h0, o, e);
    vectors++;
    if (o.rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL lw_after_sw: got %h want DEADBEEF", o.rdata); end
    drive_txn(1'b1, 3'b000, 32'h405, 32'h1234_56AB, o, e);
    vectors++;
    if (o.w1 !== 32'h0000_00AB || o.s1 !== 3'b000) begin miscompares++; $display("FAIL sb_bus: wdata %h size %b want 000000AB/000", o.w1, o.s1); end
    drive_txn(1'b1, 3'b001, 32'h406, 32'h5555_CAFE, o, e);
    vectors++;
    if (o.w1 !== 32'h0000_CAFE || o.a1 !== 32'h405) begin miscompares++; $display("FAIL sh_bus: wdata %h A_Ram %h want 0000CAFE/405", o.w1, o.a1); end
    drive_txn(1'b0, 3'b010, 32'h404, 32'h0, o, e);
    vectors++;
    if (o.rdata !== 32'hCAFE_ABEF) begin miscompares++; $display("FAIL lw_after_sb_sh: got %h want CAFEABEF", o.rdata); end
  endtask

  task automatic test_faults();
    obs_t o; exp_t e;
    drive_txn(1'b0, 3'b010, 32'h402, 32'h0, o, e);
    vectors++;
    if (o.rsp_cyc !== 1 || o.mis !== 1'b1 || o.flt !== 1'b0 || o.rdata !== 32'h0 || (o.n_rd + o.n_wr) !== 0) begin
      miscompares++; $display("FAIL lw_misaligned: cyc %0d mis %b flt %b data %h strobes %0d want 1/1/0/0/0", o.rsp_cyc, o.mis, o.flt, o.rdata, o.n_rd + o.n_wr);
    end
    drive_txn(1'b0, 3'b010, 32'h7D04, 32'h0, o, e);
    vectors++;
    if (o.rsp_cyc !== 1 || o.flt !== 1'b1 || o.mis !== 1'b0 || (o.n_rd + o.n_wr) !== 0) begin
      miscompares++; $display("FAIL lw_out_of_range: cyc %0d flt %b mis %b strobes %0d want 1/1/0/0", o.rsp_cyc, o.flt, o.mis, o.n_rd + o.n_wr);
    end
    drive_txn(1'b0, 3'b010, 32'h7D00, 32'h0, o, e);
    vectors++;
    if (o.rsp_cyc !== 3 || o.flt !== 1'b0 || o.n_rd !== 1) begin miscompares++; $display("FAIL lw_last_word: cyc %0d flt %b reads %0d want 3/0/1", o.rsp_cyc, o.flt, o.n_rd); end
    drive_txn(1'b0, 3'b011, 32'h400, 32'h0, o, e);
    vectors++;
    if (o.rsp_cyc !== 1 || o.flt !== 1'b1 || (o.n_rd + o.n_wr) !== 0) begin miscompares++; $display("FAIL f3_011: cyc %0d flt %b strobes %0d want 1/1/0", o.rsp_cyc, o.flt, o.n_rd + o.n_wr); end
    drive_txn(1'b0, 3'b001, 32'h7D05, 32'h0, o, e);
    vectors++;
    if (o.mis !== 1'b1 || o.flt !== 1'b0) begin miscompares++; $display("FAIL mis_over_range: mis %b flt %b want 1/0", o.mis, o.flt); end
    drive_txn(1'b1, 3'b100, 32'h403, 32'h0, o, e);
    vectors++;
    if (o.flt !== 1'b1 || o.mis !== 1'b0 || o.n_wr !== 0) begin miscompares++; $display("FAIL store_unsigned: flt %b mis %b writes %0d want 1/0/0", o.flt, o.mis, o.n_wr); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   rd_cycles[$];
    int   rsp_cycles[$];
    logic [31:0] rdatas[$];
    e = model(1'b0, 3'b010, 32'h400, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 10 && req_ready !== 1'b1; i++) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400; req_wdata = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (MemRead === 1'b1) rd_cycles.push_back(k);
      if (rsp_valid === 1'b1) begin rsp_cycles.push_back(k); rdatas.push_back(rsp_rdata); end
    end
    req_valid = 1'b0;
    vectors++;
    if (rd_cycles.size() !== 2 || rd_cycles[0] !== 1 || rd_cycles[1] !== 5) begin
      miscompares++; $display("FAIL held_valid_reads: %0d reads, second at cycle %0d want 2 reads at 1 and 5", rd_cycles.size(), (rd_cycles.size() > 1) ? rd_cycles[1] : -1);
    end
    vectors++;
    if (rsp_cycles.size() !== 2 || rsp_cycles[0] !== 3 || rsp_cycles[1] !== 7) begin
      miscompares++; $display("FAIL held_valid_resps: %0d responses want 2 at cycles 3 and 7", rsp_cycles.size());
    end
    vectors++;
    if (rdatas.size() !== 2 || rdatas[0] !== e.rdata || rdatas[1] !== e.rdata) begin
      miscompares++; $display("FAIL held_valid_data: first %h want %h", (rdatas.size() > 0) ? rdatas[0] : 32'hx, e.rdata);
    end
  endtask

  task automatic test_reset_abort();
    int n_rsp;
    int n_rd;
    for (int ab = 1; ab <= 3; ab++) begin
      @(negedge clk);
      for (int i = 0; i < 10 && req_ready !== 1'b1; i++) @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 2; k <= ab; k++) @(negedge clk);
      resetn = 1'b0;
      #1;
      vectors++;
      if (MemRead !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
        miscompares++; $display("FAIL abort_%0d_during: MemRead=%b rsp_valid=%b ready=%b want 0/0/0", ab, MemRead, rsp_valid, req_ready);
      end
      @(negedge clk);
      resetn = 1'b1;
      n_rsp = 0; n_rd = 0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (k == 1) begin
          vectors++;
          if (req_ready !== 1'b1) begin miscompares++; $display("FAIL abort_%0d_ready: got %b want 1", ab, req_ready); end
        end
        if (rsp_valid === 1'b1) n_rsp++;
        if (MemRead === 1'b1) n_rd++;
      end
      vectors++;
      if (n_rsp !== 0 || n_rd !== 0) begin miscompares++; $display("FAIL abort_%0d_after: rsp %0d reads %0d want 0/0", ab, n_rsp, n_rd); end
    end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int n = 0; n < 60; n++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 4) == 0) ? 32'h7D00 + 32'($urandom_range(0, 15))
                                         : 32'h400 + 32'($urandom_range(0, 63));
      drive_txn(we, f3, addr, $urandom, o, e);
      vectors++;
      if (o.rsp_cyc !== e.cyc || o.mis !== e.mis || o.flt !== e.flt) begin
        miscompares++; $display("FAIL rand_%0d_status: we=%b f3=%b addr=%h cyc %0d mis %b flt %b want %0d/%b/%b", n, we, f3, addr, o.rsp_cyc, o.mis, o.flt, e.cyc, e.mis, e.flt);
      end
      vectors++;
      if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL rand_%0d_data: we=%b f3=%b addr=%h got %h want %h", n, we, f3, addr, o.rdata, e.rdata); end
      vectors++;
      if ((o.n_rd + o.n_wr) !== e.accesses || o.n_both !== 0 || (we && o.n_rd !== 0) || (!we && o.n_wr !== 0)) begin
        miscompares++; $display("FAIL rand_%0d_strobes: reads %0d writes %0d both %0d want %0d access", n, o.n_rd, o.n_wr, o.n_both, e.accesses);
      end
      vectors++;
      if (o.rdy_after !== 1'b1 || o.idle_bus !== 32'h0) begin miscompares++; $display("FAIL rand_%0d_idle: ready %b bus %h want 1/0", n, o.rdy_after, o.idle_bus); end
    end
  endtask

  initial begin
    dev_mem[32'h100] = 32'h8081_F2F3;
    ref_mem[32'h400] = 8'hF3;
    ref_mem[32'h401] = 8'hF2;
    ref_mem[32'h402] = 8'h81;
    ref_mem[32'h403] = 8'h80;
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
